hazard_stall_ctrl: RTL and testbench

Control block that drives the write-enable, bubble and flush inputs of the IF/ID and ID/EX pipeline registers in the 5-stage MIPS pipeline.
- Reads the EX-stage fields that ID/EX outputs (MemRead, rt) and the ID-stage source registers.
- Detects load-use hazards and inserts exactly one bubble into ID/EX.
- Flushes IF/ID on a taken branch or jump.
- Freezes the whole pipeline while data memory is busy, with a wait-timeout monitor and a stall-cycle statistic counter.

---
 rtl/hazard_stall_ctrl.sv | 129 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller for a 5-stage MIPS core: load-use bubbles,
// branch flushes and memory-wait freezes with a timeout and a stall counter.
module hazard_stall_ctrl #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_Rt_i,
    input  logic [4:0]       IFID_Rs_i,
    input  logic [4:0]       IFID_Rt_i,
    input  logic             IFID_UsesRt_i,
    input  logic             Branch_i,
    input  logic             MemBusy_i,
    output logic             PCWrite_o,
    output logic             IFIDWrite_o,
    output logic             IDEXBubble_o,
    output logic             IFIDFlush_o,
    output logic             PipeFreeze_o,
    output logic             Timeout_o,
    output logic [CNT_W-1:0] StallCount_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_MEM_WAIT = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             timeout_q, timeout_d;

    logic             hazard_s;
    logic             hazard_eff_s;
    logic             pc_write_s;
    logic             ifid_write_s;
    logic             idex_bubble_s;
    logic             ifid_flush_s;
    logic             pipe_freeze_s;

    // Load-use hazard: the load in EX writes a register the ID instruction reads.
    always_comb begin
        hazard_s = IDEX_MemRead_i && (IDEX_Rt_i != 5'd0) &&
                   ((IDEX_Rt_i == IFID_Rs_i) ||
                    (IFID_UsesRt_i && (IDEX_Rt_i == IFID_Rt_i)));
        // The ID instruction already saw its bubble; do not stall it twice.
        hazard_eff_s = hazard_s && (state_q != ST_LU_STALL);
    end

    // Next state, wait counter and pipeline control outputs.
    always_comb begin
        pc_write_s    = 1'b1;
        ifid_write_s  = 1'b1;
        idex_bubble_s = 1'b0;
        ifid_flush_s  = 1'b0;
        pipe_freeze_s = 1'b0;
        state_d       = ST_RUN;
        wait_cnt_d    = '0;
        if (rst_i) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN, ST_LU_STALL, ST_MEM_WAIT: begin
                    // Busy memory wins over everything; a non-busy MEM_WAIT acts as RUN.
                    if (MemBusy_i) begin
                        pipe_freeze_s = 1'b1;
                        pc_write_s    = 1'b0;
                        ifid_write_s  = 1'b0;
                        state_d       = ST_MEM_WAIT;
                        wait_cnt_d    = (state_q == ST_MEM_WAIT) ? sat_inc(wait_cnt_q) : CNT_ONE;
                    end else if (hazard_eff_s) begin
                        pc_write_s    = 1'b0;
                        ifid_write_s  = 1'b0;
                        idex_bubble_s = 1'b1;
                        state_d       = ST_LU_STALL;
                    end else if (Branch_i) begin
                        ifid_flush_s  = 1'b1;
                        state_d       = ST_RUN;
                    end else begin
                        state_d       = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Sticky timeout and saturating stall statistic.
    always_comb begin
        timeout_d   = timeout_q || (wait_cnt_d >= WAIT_LIM);
        stall_cnt_d = pc_write_s ? stall_cnt_q : sat_inc(stall_cnt_q);
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign PCWrite_o    = pc_write_s;
    assign IFIDWrite_o  = ifid_write_s;
    assign IDEXBubble_o = idex_bubble_s;
    assign IFIDFlush_o  = ifid_flush_s;
    assign PipeFreeze_o = pipe_freeze_s;
    assign Timeout_o    = timeout_q;
    assign StallCount_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed vectors plus a cycle-level
// behavioural model compared on every falling edge.
module tb_hazard_stall_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 16;
    localparam int CNT_SAT  = 65535;

    logic             clk = 1'b0;
    logic             rst;
    logic             memread;
    logic [4:0]       ex_rt;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             uses_rt;
    logic             branch;
    logic             busy;
    logic             pc_write;
    logic             ifid_write;
    logic             bubble;
    logic             flush;
    logic             freeze;
    logic             timeout;
    logic [CNT_W-1:0] stall_count;

    int errors = 0;
    int checks = 0;

    // Model state: meaning is "as it will be after the next rising edge".
    bit m_valid       = 1'b0;
    bit m_prev_bubble = 1'b0;
    int m_run         = 0;
    bit m_timeout     = 1'b0;
    int m_stall       = 0;

    hazard_stall_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .IDEX_MemRead_i (memread),
        .IDEX_Rt_i      (ex_rt),
        .IFID_Rs_i      (id_rs),
        .IFID_Rt_i      (id_rt),
        .IFID_UsesRt_i  (uses_rt),
        .Branch_i       (branch),
        .MemBusy_i      (busy),
        .PCWrite_o      (pc_write),
        .IFIDWrite_o    (ifid_write),
        .IDEXBubble_o   (bubble),
        .IFIDFlush_o    (flush),
        .PipeFreeze_o   (freeze),
        .Timeout_o      (timeout),
        .StallCount_o   (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model and per-cycle comparison.
    always @(negedge clk) begin
        bit hz, hz_eff, e_pc, e_bub, e_fl, e_fz;
        hz = memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (uses_rt && ex_rt == id_rt));
        hz_eff = hz && !m_prev_bubble;
        if (rst) begin
            e_pc = 1'b1; e_bub = 1'b0; e_fl = 1'b0; e_fz = 1'b0;
        end else begin
            e_fz  = busy;
            e_pc  = !busy && !hz_eff;
            e_bub = !busy && hz_eff;
            e_fl  = !busy && !hz_eff && branch;
        end
        check("model_pcwrite", {31'd0, pc_write}, {31'd0, e_pc});
        check("model_ifidwrite", {31'd0, ifid_write}, {31'd0, e_pc});
        check("model_bubble", {31'd0, bubble}, {31'd0, e_bub});
        check("model_flush", {31'd0, flush}, {31'd0, e_fl});
        check("model_freeze", {31'd0, freeze}, {31'd0, e_fz});
        if (m_valid) begin
            check("model_timeout", {31'd0, timeout}, {31'd0, m_timeout});
            check("model_stallcount", {16'd0, stall_count}, m_stall);
        end
        if (rst) begin
            m_valid = 1'b1; m_prev_bubble = 1'b0; m_run = 0; m_timeout = 1'b0; m_stall = 0;
        end else begin
            m_prev_bubble = e_bub;
            m_run = busy ? m_run + 1 : 0;
            if (m_run >= MAX_WAIT) m_timeout = 1'b1;
            if (!e_pc && m_stall < CNT_SAT) m_stall++;
        end
    end

    task automatic drive(input bit mr, input logic [4:0] xrt, input logic [4:0] rs,
                         input logic [4:0] rt, input bit ur, input bit br, input bit bz);
        memread = mr; ex_rt = xrt; id_rs = rs; id_rt = rt; uses_rt = ur; branch = br; busy = bz;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Load-use stall: exactly one bubble, hazard masked on the following cycle
        drive(1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
        check("lu_pcwrite", {31'd0, pc_write}, 32'd0);
        check("lu_ifidwrite", {31'd0, ifid_write}, 32'd0);
        check("lu_bubble", {31'd0, bubble}, 32'd1);
        tick();
        drive(1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
        check("lu_next_pcwrite", {31'd0, pc_write}, 32'd1);
        check("lu_next_bubble", {31'd0, bubble}, 32'd0);
        check("lu_stallcount", {16'd0, stall_count}, 32'd1);
        tick();
        idle();
        tick();

        // Zero register and rt masking
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("r0_pcwrite", {31'd0, pc_write}, 32'd1);
        drive(1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0);
        check("rt_unused_pcwrite", {31'd0, pc_write}, 32'd1);
        drive(1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0);
        check("rt_used_bubble", {31'd0, bubble}, 32'd1);
        check("rt_used_pcwrite", {31'd0, pc_write}, 32'd0);
        tick();
        idle();
        tick();

        // Branch flush, and branch suppressed by a coincident hazard
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        check("br_flush", {31'd0, flush}, 32'd1);
        check("br_pcwrite", {31'd0, pc_write}, 32'd1);
        tick();
        drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0);
        check("br_hz_flush", {31'd0, flush}, 32'd0);
        check("br_hz_bubble", {31'd0, bubble}, 32'd1);
        tick();
        drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0);
        check("br_after_stall_flush", {31'd0, flush}, 32'd1);
        tick();
        idle();
        tick();

        // Memory wait of three cycles
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
            check("mw_freeze", {31'd0, freeze}, 32'd1);
            check("mw_pcwrite", {31'd0, pc_write}, 32'd0);
            tick();
        end
        idle();
        check("mw_stallcount", {16'd0, stall_count}, 32'd3);
        check("mw_timeout", {31'd0, timeout}, 32'd0);
        check("mw_resume_pcwrite", {31'd0, pc_write}, 32'd1);
        check("mw_resume_freeze", {31'd0, freeze}, 32'd0);
        tick();

        // Timeout after MAX_WAIT consecutive busy cycles, sticky until reset
        for (int i = 1; i <= 6; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
            check("to_during_busy", {31'd0, timeout}, (i >= 5) ? 32'd1 : 32'd0);
            tick();
        end
        idle();
        check("to_sticky", {31'd0, timeout}, 32'd1);
        tick();
        do_reset();
        idle();
        check("to_cleared", {31'd0, timeout}, 32'd0);

        // Reset during LU_STALL: the held hazard must stall again from RUN
        drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
        check("rst_lu_pcwrite", {31'd0, pc_write}, 32'd1);
        check("rst_lu_bubble", {31'd0, bubble}, 32'd0);
        tick();
        rst = 1'b0;
        drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
        check("rst_lu_run_bubble", {31'd0, bubble}, 32'd1);
        check("rst_lu_stallcount", {16'd0, stall_count}, 32'd0);
        tick();
        idle();
        tick();

        // Reset during MEM_WAIT: the wait count must restart from zero
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        check("rst_mw_freeze", {31'd0, freeze}, 32'd0);
        check("rst_mw_pcwrite", {31'd0, pc_write}, 32'd1);
        tick();
        rst = 1'b0;
        idle();
        check("rst_mw_stallcount", {16'd0, stall_count}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        idle();
        check("rst_mw_no_carry_timeout", {31'd0, timeout}, 32'd0);
        check("rst_mw_stallcount3", {16'd0, stall_count}, 32'd3);
        tick();

        // Stall counter saturation under a long freeze
        do_reset();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < CNT_SAT + 5; i++) begin
            tick();
        end
        idle();
        check("sat_stallcount", {16'd0, stall_count}, 32'h0000FFFF);
        check("sat_timeout", {31'd0, timeout}, 32'd1);
        tick();
        do_reset();
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
